// File: rtl/step_ramp_generator.sv
// Trapezoidal step/direction pulse generator for an external stepper driver.
// Latency: dir_out updates on the start edge; the first step_out rise is DIR_SETUP edges later.
// Backpressure: none; start_in is ignored while busy, and abort_in stops a move on the next edge.
module step_ramp_generator #(
    parameter int STEP_WIDTH   = 24,
    parameter int PERIOD_WIDTH = 16,
    parameter int PULSE_WIDTH  = 4,
    parameter int DIR_SETUP    = 2
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    start_in,
    input  logic                    abort_in,
    input  logic [STEP_WIDTH-1:0]   steps_in,
    input  logic                    dir_in,
    input  logic [PERIOD_WIDTH-1:0] min_period_in,
    input  logic [PERIOD_WIDTH-1:0] max_period_in,
    input  logic [PERIOD_WIDTH-1:0] accel_in,
    output logic                    step_out,
    output logic                    dir_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [STEP_WIDTH-1:0]   steps_done_out
);

    localparam int SC_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    // A period must leave at least one low cycle after the pulse.
    localparam logic [PERIOD_WIDTH-1:0] LP_MIN_PERIOD = PERIOD_WIDTH'(PULSE_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SC_W-1:0]         r_setup_cnt, w_setup_cnt_nxt;
    logic [PERIOD_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [PERIOD_WIDTH-1:0] r_period, w_period_nxt;
    logic [PERIOD_WIDTH-1:0] r_min_eff, w_min_eff_nxt;
    logic [PERIOD_WIDTH-1:0] r_max_eff, w_max_eff_nxt;
    logic [PERIOD_WIDTH-1:0] r_accel, w_accel_nxt;
    logic [STEP_WIDTH-1:0]   r_ramp, w_ramp_nxt;
    logic [STEP_WIDTH-1:0]   r_remaining, w_remaining_nxt;
    logic [STEP_WIDTH-1:0]   r_steps_done, w_steps_done_nxt;
    logic                    r_step, w_step_nxt;
    logic                    r_dir, w_dir_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_done, w_done_nxt;

    logic [PERIOD_WIDTH-1:0] w_min_in, w_max_in, w_cnt_inc;
    logic [PERIOD_WIDTH:0]   w_inc_sum;
    logic [PERIOD_WIDTH-1:0] w_period_up, w_period_dn;
    logic [STEP_WIDTH-1:0]   w_rem_dec;
    logic                    w_step_end;

    assign step_out       = r_step;
    assign dir_out        = r_dir;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign steps_done_out = r_steps_done;

    // Effective period limits from the live inputs, and saturating ramp arithmetic on latched values.
    always_comb begin
        w_min_in    = (min_period_in > LP_MIN_PERIOD) ? min_period_in : LP_MIN_PERIOD;
        w_max_in    = (max_period_in > w_min_in) ? max_period_in : w_min_in;
        w_cnt_inc   = r_cnt + 1'b1;
        w_rem_dec   = r_remaining - 1'b1;
        w_step_end  = (r_cnt == (r_period - 1'b1));
        w_inc_sum   = {1'b0, r_period} + {1'b0, r_accel};
        w_period_up = (w_inc_sum > {1'b0, r_max_eff}) ? r_max_eff : w_inc_sum[PERIOD_WIDTH-1:0];
        // Only used when r_period > r_min_eff, so the difference cannot wrap.
        w_period_dn = (r_accel >= (r_period - r_min_eff)) ? r_min_eff : (r_period - r_accel);
    end

    // Next-state and next-output logic; abort takes priority over step counting.
    always_comb begin
        w_state_nxt      = r_state;
        w_setup_cnt_nxt  = r_setup_cnt;
        w_cnt_nxt        = r_cnt;
        w_period_nxt     = r_period;
        w_min_eff_nxt    = r_min_eff;
        w_max_eff_nxt    = r_max_eff;
        w_accel_nxt      = r_accel;
        w_ramp_nxt       = r_ramp;
        w_remaining_nxt  = r_remaining;
        w_steps_done_nxt = r_steps_done;
        w_step_nxt       = r_step;
        w_dir_nxt        = r_dir;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_in && !abort_in) begin
                    w_steps_done_nxt = '0;
                    if (steps_in != '0) begin
                        w_state_nxt     = ST_SETUP;
                        w_setup_cnt_nxt = '0;
                        w_dir_nxt       = dir_in;
                        w_busy_nxt      = 1'b1;
                        w_min_eff_nxt   = w_min_in;
                        w_max_eff_nxt   = w_max_in;
                        w_accel_nxt     = accel_in;
                        w_period_nxt    = w_max_in;
                        w_ramp_nxt      = '0;
                        w_remaining_nxt = steps_in;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (abort_in) begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_setup_cnt == SC_W'(DIR_SETUP - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_setup_cnt_nxt = r_setup_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_in) begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (w_step_end) begin
                    w_remaining_nxt  = w_rem_dec;
                    w_steps_done_nxt = r_steps_done + 1'b1;
                    w_cnt_nxt        = '0;
                    if (w_rem_dec == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_step_nxt  = 1'b0;
                    end else begin
                        w_step_nxt = 1'b1;
                        // Decelerate once the remaining steps match the steps spent accelerating.
                        if (w_rem_dec <= r_ramp) begin
                            w_period_nxt = w_period_up;
                            if (r_ramp != '0) w_ramp_nxt = r_ramp - 1'b1;
                        end else if ((r_accel != '0) && (r_period > r_min_eff)) begin
                            w_period_nxt = w_period_dn;
                            w_ramp_nxt   = r_ramp + 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_step_nxt = (w_cnt_inc < PERIOD_WIDTH'(PULSE_WIDTH));
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately, including step_out.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state      <= ST_IDLE;
            r_setup_cnt  <= '0;
            r_cnt        <= '0;
            r_period     <= '0;
            r_min_eff    <= '0;
            r_max_eff    <= '0;
            r_accel      <= '0;
            r_ramp       <= '0;
            r_remaining  <= '0;
            r_steps_done <= '0;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_setup_cnt  <= w_setup_cnt_nxt;
            r_cnt        <= w_cnt_nxt;
            r_period     <= w_period_nxt;
            r_min_eff    <= w_min_eff_nxt;
            r_max_eff    <= w_max_eff_nxt;
            r_accel      <= w_accel_nxt;
            r_ramp       <= w_ramp_nxt;
            r_remaining  <= w_remaining_nxt;
            r_steps_done <= w_steps_done_nxt;
            r_step       <= w_step_nxt;
            r_dir        <= w_dir_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_step_ramp_generator.sv
// Testbench for step_ramp_generator: expected step rise and done cycles are queued at start time.
// Latency: outputs are sampled on the falling clock edge, away from the active edge.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_step_ramp_generator;

    localparam int SW = 24;
    localparam int PW = 16;

    logic          clk_in = 1'b0;
    logic          reset_n_in = 1'b0;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic [SW-1:0] steps_in = '0;
    logic          dir_in = 1'b0;
    logic [PW-1:0] min_period_in = '0;
    logic [PW-1:0] max_period_in = '0;
    logic [PW-1:0] accel_in = '0;
    logic          step_out, dir_out, busy_out, done_out;
    logic [SW-1:0] steps_done_out;

    step_ramp_generator #(
        .STEP_WIDTH(SW), .PERIOD_WIDTH(PW), .PULSE_WIDTH(4), .DIR_SETUP(2)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in), .abort_in(abort_in),
        .steps_in(steps_in), .dir_in(dir_in), .min_period_in(min_period_in),
        .max_period_in(max_period_in), .accel_in(accel_in), .step_out(step_out),
        .dir_out(dir_out), .busy_out(busy_out), .done_out(done_out),
        .steps_done_out(steps_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Index of the most recent rising edge; sampled at negedge it names the edge just taken.
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_rise[$];
    int   exp_done[$];
    bit   pw_check = 1'b1;
    logic prev_step = 1'b0;
    int   last_rise = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // Output monitor: every step rise and done pulse must match the head of its queue.
    always @(negedge clk_in) begin
        if (step_out && !prev_step) begin
            last_rise = cyc;
            if (exp_rise.size() > 0) check("rise_cycle", cyc, exp_rise.pop_front());
            else check("rise_unexpected", cyc, -1);
        end
        if (!step_out && prev_step && pw_check) check("pulse_width", cyc - last_rise, 4);
        if (done_out) begin
            if (exp_done.size() > 0) check("done_cycle", cyc, exp_done.pop_front());
            else check("done_unexpected", cyc, -1);
        end
        prev_step = step_out;
    end

    // Reference model of the ramp: pushes the expected rise and done cycles for a move starting at e0.
    task automatic push_model(input int steps, input int mn, input int mx, input int acc, input int e0);
        int mne, mxe, p, np, a, t, rem;
        mne = (mn > 5) ? mn : 5;
        mxe = (mx > mne) ? mx : mne;
        p = mxe; a = 0; t = e0 + 2; rem = steps;
        if (steps == 0) begin
            exp_done.push_back(e0);
            return;
        end
        for (int k = 0; k < steps; k++) begin
            exp_rise.push_back(t);
            rem--;
            if (rem == 0) begin
                exp_done.push_back(t + p);
            end else begin
                np = p;
                if (rem <= a) begin
                    np = p + acc;
                    if (np > mxe) np = mxe;
                    if (a > 0) a--;
                end else if (acc != 0 && p > mne) begin
                    np = p - acc;
                    if (np < mne) np = mne;
                    a++;
                end
                t += p;
                p = np;
            end
        end
    endtask

    // Drive a one-cycle start; e0 is the edge that samples it. Returns at the negedge after e0.
    task automatic start_move(input int steps, input bit dir, input int mn, input int mx,
                              input int acc, input bit push, output int e0);
        @(negedge clk_in);
        e0 = cyc + 1;
        steps_in = SW'(steps); dir_in = dir;
        min_period_in = PW'(mn); max_period_in = PW'(mx); accel_in = PW'(acc);
        start_in = 1'b1;
        if (push) push_model(steps, mn, mx, acc, e0);
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_rise.size() != 0 || exp_done.size() != 0) && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        repeat (3) @(negedge clk_in);
        check("rise_queue_empty", exp_rise.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk_in);
    endtask

    task automatic single_step_scenario(input string tag);
        int e0;
        start_move(1, 1'b1, 10, 10, 0, 1'b1, e0);
        check({tag, "_dir_at_e0"}, dir_out, 1);
        check({tag, "_busy_at_e0"}, busy_out, 1);
        check({tag, "_sdone_at_e0"}, steps_done_out, 0);
        wait_drain(100);
        check({tag, "_busy_end"}, busy_out, 0);
        check({tag, "_steps_done"}, steps_done_out, 1);
    endtask

    initial begin
        int e0;
        #12;
        check("reset_step", step_out, 0);
        check("reset_busy", busy_out, 0);
        check("reset_done", done_out, 0);
        check("reset_dir", dir_out, 0);
        check("reset_sdone", steps_done_out, 0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        single_step_scenario("single");

        // Trapezoid, with an ignored start attempt mid-move.
        start_move(6, 1'b1, 10, 20, 5, 1'b1, e0);
        wait_cycle(e0 + 10);
        steps_in = SW'(1); dir_in = 1'b0; max_period_in = PW'(50); start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_drain(300);
        check("trap_steps_done", steps_done_out, 6);
        check("trap_dir_held", dir_out, 1);
        check("trap_busy_end", busy_out, 0);

        // Clamping: both limits below PULSE_WIDTH+1.
        start_move(3, 1'b0, 2, 1, 0, 1'b1, e0);
        check("clamp_dir", dir_out, 0);
        wait_drain(100);
        check("clamp_steps_done", steps_done_out, 3);

        // Zero steps.
        start_move(0, 1'b1, 10, 10, 0, 1'b1, e0);
        check("zero_busy", busy_out, 0);
        wait_drain(20);
        check("zero_steps_done", steps_done_out, 0);

        // Start together with abort in IDLE is dropped.
        @(negedge clk_in);
        steps_in = SW'(2); abort_in = 1'b1; start_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0; start_in = 1'b0;
        check("abort_start_busy", busy_out, 0);
        wait_drain(20);

        // Abort mid-pulse of step 3.
        start_move(6, 1'b1, 10, 20, 5, 1'b0, e0);
        exp_rise.push_back(e0 + 2);
        exp_rise.push_back(e0 + 22);
        exp_rise.push_back(e0 + 37);
        pw_check = 1'b0;
        wait_cycle(e0 + 38);
        check("abort_step_high", step_out, 1);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check("abort_step_low", step_out, 0);
        check("abort_busy", busy_out, 0);
        check("abort_done", done_out, 0);
        check("abort_steps_done", steps_done_out, 2);
        repeat (40) @(negedge clk_in);
        wait_drain(10);
        pw_check = 1'b1;
        single_step_scenario("after_abort");

        // Asynchronous reset while step_out is high.
        start_move(3, 1'b1, 10, 10, 0, 1'b1, e0);
        pw_check = 1'b0;
        wait_cycle(e0 + 3);
        check("rst_pre_step", step_out, 1);
        #2 reset_n_in = 1'b0;
        #1;
        check("rst_step", step_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_done", done_out, 0);
        check("rst_sdone", steps_done_out, 0);
        exp_rise.delete();
        exp_done.delete();
        repeat (2) @(negedge clk_in);
        reset_n_in = 1'b1;
        @(negedge clk_in);
        pw_check = 1'b1;
        single_step_scenario("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/step_ramp_generator.md
Name: step_ramp_generator

Overview:
- Trapezoidal step-pulse generator. It drives the step/direction pins of the external stepper driver, alongside motor_driver, which handles the SPI configuration of the same driver chip.
- The CPU writes a move of N steps (direction, min/max period, accel) through the IO register block. The block accelerates, cruises and decelerates symmetrically, then reports completion.

Parameters:
- STEP_WIDTH, 24, width of step count, remaining and ramp counters.
- PERIOD_WIDTH, 16, width of all period/accel values (units: clk_in cycles).
- PULSE_WIDTH, 4, step_out high time in cycles per step.
- DIR_SETUP, 2, cycles between dir_out update and first step_out rise.

Ports:
- clk_in  input  1  system clock (25 MHz).
- reset_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  start move, sampled on rising clk_in edge.
- abort_in  input  1  immediate stop.
- steps_in  input  STEP_WIDTH  number of steps in move.
- dir_in  input  1  direction for move.
- min_period_in  input  PERIOD_WIDTH  cruise (fastest) step period.
- max_period_in  input  PERIOD_WIDTH  start/stop (slowest) step period.
- accel_in  input  PERIOD_WIDTH  period change per step during ramps.
- step_out  output  1  step pulse to driver.
- dir_out  output  1  direction pin.
- busy_out  output  1  move in progress.
- done_out  output  1  one-cycle pulse on normal completion.
- steps_done_out  output  STEP_WIDTH  steps issued in current/last move.

Behaviour:
- Reset (async, reset_n_in=0): state IDLE; all outputs 0; internal counters 0. Reset mid-move drops step_out in the same instant and abandons the move.
- All outputs are registered. States: IDLE, SETUP, RUN.
- IDLE, start_in=1, steps_in!=0: latch all inputs; dir_out<=dir_in; busy_out<=1; steps_done_out<=0; period<=max_eff; ramp count a<=0; remaining<=steps_in; go to SETUP.
- IDLE, start_in=1, steps_in==0: done_out=1 next cycle; no step; busy_out stays 0; steps_done_out<=0.
- Effective limits:
  - min_eff = max(min_period_in, PULSE_WIDTH+1).
  - max_eff = max(max_period_in, min_eff).
- SETUP: hold for DIR_SETUP cycles, then enter RUN with cnt=0 and step_out<=1. The first rise is DIR_SETUP edges after the start edge.
- RUN:
  - cnt counts 0..period-1; step_out=1 while cnt<PULSE_WIDTH.
  - Successive rising edges of step_out are exactly `period` cycles apart, using the period in force at that step.
- At cnt==period-1: remaining-=1, steps_done_out+=1, and with r = new remaining:
  - r==0: state IDLE, busy_out<=0, done_out<=1 for one cycle.
  - r<=a (decel): period<=min(period+accel, max_eff), saturating with no overflow; a<=a-1 if a>0.
  - else if period>min_eff (accel): period<=max(period-accel, min_eff), saturating with no underflow; a<=a+1.
  - else: cruise, period unchanged.
- accel_in==0: constant period max_eff; a stays 0.
- abort_in=1 in SETUP/RUN (priority over the step counting and completion logic): next edge goes to IDLE. step_out<=0, busy_out<=0, done_out stays 0, steps_done_out holds its count.
- start_in while busy_out=1 is ignored. Input changes during a move have no effect; values are latched at start.
- abort_in and start_in together in IDLE: the start is ignored.

Test Plan:
- Single step: PULSE_WIDTH=4, DIR_SETUP=2, steps=1, max=10, min=10, accel=0, start at edge E0.
  - dir_out=1 at E0; step_out high E2..E6.
  - done_out pulse and busy_out low at E12; steps_done_out=1.
- Trapezoid: steps=6, max=20, min=10, accel=5.
  - Rise-to-rise intervals 20,15,10,10,15; done_out at E2+90; steps_done_out=6.
- Clamping: min=2, max=1, PW=4, steps=3.
  - Every interval is 5 cycles; step_out high 4 of 5 cycles.
- Zero steps: steps=0, start.
  - done_out one cycle next edge; step_out never rises; busy_out stays 0.
- Abort: trapezoid move, abort asserted mid-pulse of step 3.
  - step_out low next edge, busy_out 0, no done_out, steps_done_out=2.
  - A later start of steps=1 behaves exactly as in the single-step scenario.
- Reset mid-move: reset_n_in low while step_out=1.
  - step_out=0 and all outputs 0 without a clock edge.
  - After release, a start behaves as from power-up.
